// File: rtl/ysyx_22041071_axi_r_pkg.sv
// rtl/ysyx_22041071_axi_r_pkg.sv - shared constants for the AXI4 read master
package ysyx_22041071_axi_r_pkg;

    localparam int ID_W_DEF   = 4;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;
    localparam int LEN_W_DEF  = 8;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] AXI_BURST_TYPE_INCR = 2'b01;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    // Response codes are ordered by severity, so the worst is the numeric max.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ysyx_22041071_axi_r_lane.sv
// rtl/ysyx_22041071_axi_r_lane.sv - narrow-read lane extraction (shift to bit 0, zero-extend)
module ysyx_22041071_axi_r_lane
    import ysyx_22041071_axi_r_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        offset,
    input  logic [1:0]        size,
    output logic [DATA_W-1:0] lane_data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted   = data >> {offset, 3'b000};
        lane_data = '0;
        case (size)
            2'b00:   lane_data[7:0]  = shifted[7:0];
            2'b01:   lane_data[15:0] = shifted[15:0];
            2'b10:   lane_data[31:0] = shifted[31:0];
            default: lane_data       = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22041071_axi_r.sv
// rtl/ysyx_22041071_axi_r.sv - AXI4 AR/R read master, one outstanding transaction
// Optional rid/rlast checking with cpu_r_err: YSYX_22041071_AXI_R_PROTO_CHECK_EN
module ysyx_22041071_axi_r
    import ysyx_22041071_axi_r_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ar_valid,
    output logic              cpu_ar_ready,
    input  logic [ID_W-1:0]   cpu_id,
    input  logic [63:0]       cpu_addr,
    input  logic [LEN_W-1:0]  cpu_ar_len,
    input  logic [1:0]        cpu_size,
    output logic              cpu_r_valid,
    output logic [DATA_W-1:0] cpu_r_data,
    output logic              cpu_r_last,
    output logic [1:0]        cpu_r_resp,
`ifdef YSYX_22041071_AXI_R_PROTO_CHECK_EN
    output logic              cpu_r_err,
`endif
    input  logic              axi_ar_ready_i,
    output logic              axi_ar_valid_o,
    output logic [ID_W-1:0]   axi_ar_id_o,
    output logic [ADDR_W-1:0] axi_ar_addr_o,
    output logic [LEN_W-1:0]  axi_ar_len_o,
    output logic [2:0]        axi_ar_size_o,
    output logic [1:0]        axi_ar_burst_o,
    output logic [2:0]        axi_ar_prot_o,
    output logic              axi_ar_user_o,
    output logic              axi_ar_lock_o,
    output logic [3:0]        axi_ar_cache_o,
    output logic [3:0]        axi_ar_qos_o,
    output logic [3:0]        axi_ar_region_o,
    output logic              axi_r_ready_o,
    input  logic              axi_r_valid_i,
    input  logic [ID_W-1:0]   axi_r_id_i,
    input  logic [DATA_W-1:0] axi_r_data_i,
    input  logic [1:0]        axi_r_resp_i,
    input  logic              axi_r_last_i,
    input  logic              axi_r_user_i
);

    logic [1:0]        state;
    logic [LEN_W-1:0]  beat_cnt;
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] lane_data;
    logic              beat;
    logic              final_beat;
    logic              accept;

    assign cpu_ar_ready = (state == R_IDLE);
    assign accept       = cpu_ar_ready && cpu_ar_valid;
    assign beat         = (state == R_DATA) && axi_r_valid_i && axi_r_ready_o;
    // Compare before incrementing so len=255 finishes without the counter wrapping.
    assign final_beat   = (beat_cnt == axi_ar_len_o);

    assign axi_ar_prot_o   = 3'd0;
    assign axi_ar_user_o   = 1'b0;
    assign axi_ar_lock_o   = 1'b0;
    assign axi_ar_cache_o  = 4'd0;
    assign axi_ar_qos_o    = 4'd0;
    assign axi_ar_region_o = 4'd0;

    ysyx_22041071_axi_r_lane #(.DATA_W(DATA_W)) u_lane (
        .data      (axi_r_data_i),
        .offset    (off_q),
        .size      (size_q),
        .lane_data (lane_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= R_IDLE;
            beat_cnt       <= '0;
            off_q          <= '0;
            size_q         <= '0;
            axi_ar_valid_o <= 1'b0;
            axi_ar_id_o    <= '0;
            axi_ar_addr_o  <= '0;
            axi_ar_len_o   <= '0;
            axi_ar_size_o  <= '0;
            axi_ar_burst_o <= '0;
            axi_r_ready_o  <= 1'b0;
            cpu_r_valid    <= 1'b0;
            cpu_r_data     <= '0;
            cpu_r_last     <= 1'b0;
            cpu_r_resp     <= '0;
        end else begin
            cpu_r_valid <= 1'b0;
            cpu_r_last  <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (cpu_ar_valid) begin
                        off_q          <= cpu_addr[2:0];
                        size_q         <= cpu_size;
                        axi_ar_id_o    <= cpu_id;
                        axi_ar_addr_o  <= {cpu_addr[ADDR_W-1:3], 3'b000};
                        axi_ar_len_o   <= cpu_ar_len;
                        axi_ar_size_o  <= {1'b0, cpu_size};
                        axi_ar_burst_o <= AXI_BURST_TYPE_INCR;
                        axi_ar_valid_o <= 1'b1;
                        cpu_r_resp     <= '0;
                        state          <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (axi_ar_ready_i) begin
                        axi_ar_valid_o <= 1'b0;
                        axi_r_ready_o  <= 1'b1;
                        state          <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (beat) begin
                        cpu_r_valid <= 1'b1;
                        cpu_r_data  <= (axi_ar_len_o == '0) ? lane_data : axi_r_data_i;
                        cpu_r_resp  <= resp_worst(cpu_r_resp, axi_r_resp_i);
                        cpu_r_last  <= final_beat;
                        if (final_beat) begin
                            beat_cnt      <= '0;
                            axi_r_ready_o <= 1'b0;
                            state         <= R_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

`ifdef YSYX_22041071_AXI_R_PROTO_CHECK_EN
    logic beat_err;
    assign beat_err = (axi_r_id_i != axi_ar_id_o) || (axi_r_last_i != final_beat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_r_err <= 1'b0;
        end else if (accept) begin
            cpu_r_err <= 1'b0;
        end else if (beat) begin
            cpu_r_err <= cpu_r_err | beat_err;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{cpu_addr[63:ADDR_W], axi_r_user_i, accept};
`else
    logic unused_inputs;
    assign unused_inputs = ^{cpu_addr[63:ADDR_W], axi_r_user_i, axi_r_id_i, axi_r_last_i, accept};
`endif

endmodule
